serial_subtractor: RTL and testbench

//  Bit-serial, LSB-first unsigned subtractor: out = A - B mod 2^WIDTH, one bit per clk, borrow held in one flop.

---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor_full_subtractor_bit.sv | 13 +
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor: controller states
// and the width rule for the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_e;

    localparam int SUB_WIDTH_DEFAULT = 23;

    // The counter must be able to hold WIDTH itself, hence the +1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(SUB_WIDTH_DEFAULT);

endpackage

// File: rtl/serial_subtractor_if.sv
// Load/result bundle of the serial subtractor. The slave side is the
// subtractor; the master side loads operands and consumes results.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_subtractor_pkg::SUB_WIDTH_DEFAULT
);
    logic             la;
    logic             lb;
    logic             si;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             done;
    logic             busy;
    logic             sdo;
    logic             sdo_valid;

    modport master (
        output la, lb, si, A, B,
        input  out, borrow, done, busy, sdo, sdo_valid
    );

    modport slave (
        input  la, lb, si, A, B,
        output out, borrow, done, busy, sdo, sdo_valid
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor: {bout, d} = a - b - bin.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    // A borrow leaves this bit when a is 0 and b is 1, or when a equals b
    // and a borrow arrives from below.
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: out = A - B mod 2^WIDTH, one bit
// per clock, with each difference bit also streamed on sdo.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a1_q, a1_d;
    logic [WIDTH-1:0] b1_q, b1_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             bflop_q, bflop_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic             sdo_q, sdo_d;
    logic             sdo_valid_q, sdo_valid_d;

    logic             diff_bit;
    logic             borrow_out;

    full_subtractor_bit u_fsub (
        .a    (a1_q[0]),
        .b    (b1_q[0]),
        .bin  (bflop_q),
        .d    (diff_bit),
        .bout (borrow_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a1_q        <= '0;
            b1_q        <= '0;
            out_q       <= '0;
            count_q     <= '0;
            bflop_q     <= 1'b0;
            borrow_q    <= 1'b0;
            done_q      <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            out_q       <= out_d;
            count_q     <= count_d;
            bflop_q     <= bflop_d;
            borrow_q    <= borrow_d;
            done_q      <= done_d;
            sdo_q       <= sdo_d;
            sdo_valid_q <= sdo_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        out_d       = out_q;
        count_d     = count_q;
        bflop_d     = bflop_q;
        borrow_d    = borrow_q;
        done_d      = 1'b0;
        sdo_d       = sdo_q;
        sdo_valid_d = 1'b0;

        // A load wins in every state, so it also aborts a run in progress.
        if (bus.la || bus.lb) begin
            if (bus.la) a1_d = bus.A;
            if (bus.lb) b1_d = bus.B;
            count_d = '0;
            bflop_d = 1'b0;
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED, SHIFT: begin
                    // Difference bits fill A1 from the top, so after WIDTH steps A1 holds the result.
                    a1_d        = {diff_bit, a1_q[WIDTH-1:1]};
                    b1_d        = {bus.si, b1_q[WIDTH-1:1]};
                    bflop_d     = borrow_out;
                    sdo_d       = diff_bit;
                    sdo_valid_d = 1'b1;
                    count_d     = count_q + CW'(1);
                    state_d     = SHIFT;
                    if (count_q == LAST_CNT) begin
                        out_d    = {diff_bit, a1_q[WIDTH-1:1]};
                        borrow_d = borrow_out;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.borrow    = borrow_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sdo       = sdo_q;
    assign bus.sdo_valid = sdo_valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_serial_subtractor;
    localparam int W = 23;

    typedef struct packed {
        logic [W-1:0] out;
        logic         borrow;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    logic [W-1:0] sdo_word = '0;
    int           sv_run   = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Monitor: rebuild the sdo stream and the sdo_valid run length, then
    // compare the result registers against the scoreboard on every done.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sdo_valid) begin
                sdo_word = {bus.sdo, sdo_word[W-1:1]};
                sv_run++;
            end else begin
                sv_run = 0;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want no pending result");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out", bus.out, e.out);
                    check("borrow", W'(bus.borrow), W'(e.borrow));
                    check("sdo_stream", sdo_word, e.out);
                    check("sdo_valid_len", W'(sv_run), W'(W));
                    $display("result: out=0x%0h borrow=%0b expected out=0x%0h borrow=%0b",
                             bus.out, bus.borrow, e.out, e.borrow);
                end
            end
        end
    end

    task automatic load(input logic la_v, input logic lb_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v);
        @(negedge clk);
        bus.la = la_v;
        bus.lb = lb_v;
        bus.A  = a_v;
        bus.B  = b_v;
        @(negedge clk);
        bus.la = 1'b0;
        bus.lb = 1'b0;
    endtask

    // Waits for done with a bounded budget; checks latency and the pulse shape.
    task automatic wait_done(input bit rand_si);
        int k;
        k = 0;
        for (int i = 1; i <= 3 * W; i++) begin
            if (rand_si) bus.si = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.done) begin
                k = i;
                break;
            end
        end
        check("latency", W'(k), W'(W));
        check("busy_at_done", W'(bus.busy), '0);
        @(negedge clk);
        check("done_pulse", W'(bus.done), '0);
        check("sdo_valid_after", W'(bus.sdo_valid), '0);
        bus.si = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic [W-1:0] out_v, input logic bo_v, input bit rand_si);
        exp_t e;
        e.out    = out_v;
        e.borrow = bo_v;
        load(1'b1, 1'b1, a_v, b_v);
        exp_q.push_back(e);
        check("busy_running", W'(bus.busy), W'(1));
        $display("op: A=0x%0h B=0x%0h expect out=0x%0h borrow=%0b", a_v, b_v, out_v, bo_v);
        wait_done(rand_si);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out"}, bus.out, '0);
        check({tag, "_flags"}, W'({bus.borrow, bus.done, bus.busy, bus.sdo, bus.sdo_valid}), '0);
    endtask

    initial begin
        bus.la = 1'b0;
        bus.lb = 1'b0;
        bus.si = 1'b0;
        bus.A  = '0;
        bus.B  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        // T1..T3 and extra boundary vectors
        run_op(23'd14, 23'd12, 23'd2, 1'b0, 1'b0);
        run_op(23'd1, 23'd12, 23'h7FFFF5, 1'b1, 1'b0);
        run_op(23'h7FFFFF, 23'h7FFFFF, 23'd0, 1'b0, 1'b0);
        run_op(23'd0, 23'd1, 23'h7FFFFF, 1'b1, 1'b0);
        run_op(23'h400000, 23'd1, 23'h3FFFFF, 1'b0, 1'b0);
        run_op(23'd0, 23'h7FFFFF, 23'd1, 1'b1, 1'b0);

        // T6: random si must not disturb a full-width run
        run_op(23'd14, 23'd12, 23'd2, 1'b0, 1'b1);

        // IDLE without a new load stays quiet
        repeat (W + 5) @(negedge clk);
        check("idle_busy", W'(bus.busy), '0);

        // T4: abort with an A-only load after 9 shifts. B1 (=1) has been shifted
        // right with si=0, so it is 0 by then and the rerun computes 50 - 0.
        load(1'b1, 1'b1, 23'd100, 23'd1);
        repeat (8) @(negedge clk);
        load(1'b1, 1'b0, 23'd50, 23'd999);
        begin
            exp_t e;
            e.out    = 23'd50;
            e.borrow = 1'b0;
            exp_q.push_back(e);
        end
        wait_done(1'b0);

        // T5: reset in mid-run clears every output and cancels the run
        load(1'b1, 1'b1, 23'd14, 23'd12);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrun_reset");
        repeat (W + 5) @(negedge clk);
        check("no_done_after_reset", W'(bus.busy), '0);

        // a fresh load after reset works normally
        run_op(23'd1000, 23'd1, 23'd999, 1'b0, 1'b0);

        check("scoreboard_empty", W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
